sample_msg_combiner: RTL and testbench
======================================

# sample_msg_combiner

Merges a sample stream and a message stream into one tagged word stream on a single data bus. It is the stage directly upstream of `sample_msg_splitter`: its output stream is exactly the format the splitter separates back into samples and messages. Both input streams are buffered so that samples are never dropped while a message is being emitted, and every message leaves as one contiguous burst.

## Interface

Parameters:
- `WDTH`, 32: word width of the sample and output streams. Must equal `` `MSG_WIDTH ``.
- `SAMPLE_BUF_LOG`, 6: log2 of the sample buffer depth (64 words).
- `MSG_BUF_LOG`, 6: log2 of the message buffer depth (64 words).

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high reset.
- `in_samples`, input, WDTH: sample word. Bit WDTH-1 must be 0.
- `in_samples_nd`, input, 1: `in_samples` is valid this cycle.
- `in_msg`, input, `` `MSG_WIDTH ``: message word, either a header or a payload word.
- `in_msg_nd`, input, 1: `in_msg` is valid this cycle.
- `out_data`, output, WDTH: combined stream word.
- `out_nd`, output, 1: `out_data` is valid this cycle.
- `error`, output, 1: one-cycle pulse when an input word is dropped or modified.

## Operation

Stream format:
- Sample words have bit WDTH-1 = 0.
- A message header has bit WDTH-1 = 1, with the payload length L in bits [`` `MSG_LENGTH_WIDTH ``-1:0]. L = 0 is legal.
- The header is followed by L payload words. Payload bits are forwarded unchanged.

Sample path:
- Each `in_samples_nd` word is written to the sample FIFO.
- A sample word with bit WDTH-1 = 1 has that bit forced to 0 and pulses `error`.
- A write when the sample FIFO is full drops the word and pulses `error`.

Message path:
- The input-side tracker is either in "expect header" or "in payload" state.
- In "expect header", a word with MSB = 0 is discarded and pulses `error`.
- On a valid header, if MSG FIFO free space < L+1:
  - The header and its next L `in_msg_nd` words are discarded.
  - `error` pulses once, on the header cycle.
- Otherwise all L+1 words are written.
- The complete-message count increments in the cycle the last word of a message is written (the header itself when L = 0).

Output FSM, with states IDLE, SEND_HDR and SEND_PAYLOAD:
- IDLE: if the complete count is > 0 and messages are eligible (see Configuration), go to SEND_HDR. Otherwise, if the sample FIFO is not empty, emit one sample. Otherwise no output.
- SEND_HDR:
  - Emit the header and load the payload counter with L.
  - Decrement the complete count.
  - Go to IDLE if L = 0, else to SEND_PAYLOAD.
- SEND_PAYLOAD: emit one payload word per cycle. Return to IDLE after the last word.
- Samples are never interleaved inside a message burst.
- At most one output word per cycle.
- If the count increments and decrements in the same cycle, the net change is 0.
- A simultaneous FIFO read and write on a full FIFO is allowed and is not an overflow.

Reset:
- Clears both FIFOs, the counters and the tracker (to "expect header"), and puts the FSM in IDLE.
- `out_data` = 0, `out_nd` = 0, `error` = 0.
- Reset mid-message discards the partial message on both sides.

## Timing

- Sample latency: an `in_samples_nd` in cycle n appears with `out_nd` in cycle n+2, provided the FIFO was empty and the FSM was idle.
- Message latency: last message word written in cycle n; header appears at n+2 at the earliest; payload follows on consecutive cycles.
- Throughput: one output word per cycle. Sustained input above one word per cycle (samples plus messages combined) eventually overflows a buffer.
- `out_data` and `out_nd` are registered.
- `error` is registered and asserted 1 cycle after the offending input.

## Configuration

- `SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN`:
  - Defined: messages are eligible whenever the complete count is > 0, so they pre-empt queued samples.
  - Undefined: messages are eligible only when the sample FIFO is empty, so samples have strict priority.
  - Default build leaves it undefined.

## Structure

- `` `MSG_WIDTH `` and `` `MSG_LENGTH_WIDTH `` come from the shared message definitions header, the same one the splitter uses. The header-flag bit position (WDTH-1) is defined there too.
- One sub-module, `buffer_fifo`: synchronous FIFO with parameterised width and log2 depth, exposing full, empty and free-count. It is instantiated twice.

## Test plan

- Samples 0x00000001..0x00000005 on consecutive cycles, no messages -> identical words on `out_data` at cycles n+2..n+6, `error` never asserted.
- Header 0x80000002 followed by payload 0x12345678, 0x9ABCDEF0 with no samples -> those 3 words appear contiguously, starting 2 cycles after the last payload word.
- A message sent while samples stream continuously, in both builds:
  - Macro undefined: the message appears only after the sample FIFO drains.
  - Macro defined: the message appears at the next IDLE.
  - In both builds the 3-word burst is uninterrupted and no sample is lost.
- Sample 0x80000007 -> output 0x00000007 and `error` pulses once.
- Header with L = 70 into the 64-word buffer -> all 71 words dropped, one `error` pulse. A following header 0x80000000 is output as a single word.
- Reset asserted for 1 cycle after a header 0x80000003 and 1 payload word -> no output from that message; outputs are 0 the cycle after reset; a subsequent clean message passes intact.

Source files
------------

// File: rtl/sample_msg_combiner_pkg.sv
// Shared types and message-format definitions for sample_msg_combiner.
// Provides MSG_WIDTH / MSG_LENGTH_WIDTH / MSG_HDR_BIT unless already defined by the shared message header.
`ifndef MSG_WIDTH
`define MSG_WIDTH 32
`endif
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 16
`endif
`ifndef MSG_HDR_BIT
`define MSG_HDR_BIT (`MSG_WIDTH-1)
`endif

package sample_msg_combiner_pkg;

  localparam int unsigned MSG_W = `MSG_WIDTH;
  localparam int unsigned LEN_W = `MSG_LENGTH_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_HDR,
    ST_SEND_PAYLOAD
  } out_state_t;

  typedef enum logic {
    TRK_EXP_HDR,
    TRK_IN_PAYLOAD
  } trk_state_t;

  typedef logic [LEN_W-1:0] msg_len_t;

  function automatic msg_len_t hdr_len(input logic [MSG_W-1:0] w);
    return w[LEN_W-1:0];
  endfunction

endpackage

// File: rtl/sample_msg_combiner_buffer_fifo.sv
// buffer_fifo: synchronous FIFO, parameterised width and log2 depth, with full/empty/free-count.
// Read data is the current head word (first-word fall-through); a write on full succeeds only alongside a read.
module buffer_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LOG   = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LOG:0]     free
);

  localparam logic [LOG:0] FULL_CNT = (LOG+1)'(1 << LOG);

  logic [WIDTH-1:0] mem_q [1 << LOG];
  logic [LOG-1:0]   wr_ptr_q, wr_ptr_d;
  logic [LOG-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LOG:0]     count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en && (count_q != '0);
    do_wr    = wr_en && ((count_q != FULL_CNT) || do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_wr && !do_rd)      count_d = count_q + 1'b1;
    else if (do_rd && !do_wr) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign free    = FULL_CNT - count_q;

endmodule

// File: rtl/sample_msg_combiner.sv
// Merges a sample stream and a message stream into one tagged word stream (header flag in MSB).
// Optional macro SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN: complete messages pre-empt queued samples.
module sample_msg_combiner
  import sample_msg_combiner_pkg::*;
#(
  parameter int unsigned WDTH           = 32,
  parameter int unsigned SAMPLE_BUF_LOG = 6,
  parameter int unsigned MSG_BUF_LOG    = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WDTH-1:0]       in_samples,
  input  logic                  in_samples_nd,
  input  logic [`MSG_WIDTH-1:0] in_msg,
  input  logic                  in_msg_nd,
  output logic [WDTH-1:0]       out_data,
  output logic                  out_nd,
  output logic                  error
);

  logic [WDTH-1:0]        smp_wdata, smp_rdata;
  logic                   smp_rd, smp_full, smp_empty, smp_err;
  logic [SAMPLE_BUF_LOG:0] smp_free;

  logic [MSG_W-1:0]       msg_rdata;
  logic                   msg_wr, msg_rd, msg_full, msg_empty, msg_err, msg_done;
  logic [MSG_BUF_LOG:0]   msg_free;

  trk_state_t             trk_q, trk_d;
  msg_len_t               rem_q, rem_d;
  logic                   drop_q, drop_d;
  msg_len_t               in_len;
  logic                   fits;

  logic [MSG_BUF_LOG:0]   cnt_q, cnt_d;
  logic                   cnt_dec, msg_avail, msg_eligible;

  out_state_t             state_q, state_d;
  msg_len_t               pay_cnt_q, pay_cnt_d;
  logic [WDTH-1:0]        out_data_q, out_data_d;
  logic                   out_nd_q, out_nd_d;
  logic                   error_q, error_d;

  logic                   unused_sigs;
  assign unused_sigs = ^{smp_free, msg_full, msg_empty};

  always_comb begin
    smp_wdata         = in_samples;
    smp_wdata[WDTH-1] = 1'b0;
    smp_err           = in_samples_nd && (in_samples[WDTH-1] || (smp_full && !smp_rd));
  end

  buffer_fifo #(.WIDTH(WDTH), .LOG(SAMPLE_BUF_LOG)) u_sample_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_samples_nd),
    .wr_data (smp_wdata),
    .rd_en   (smp_rd),
    .rd_data (smp_rdata),
    .full    (smp_full),
    .empty   (smp_empty),
    .free    (smp_free)
  );

  buffer_fifo #(.WIDTH(MSG_W), .LOG(MSG_BUF_LOG)) u_msg_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (msg_wr),
    .wr_data (in_msg),
    .rd_en   (msg_rd),
    .rd_data (msg_rdata),
    .full    (msg_full),
    .empty   (msg_empty),
    .free    (msg_free)
  );

  // Space for the whole message is reserved at the header, so payload writes never overflow.
  always_comb begin
    trk_d    = trk_q;
    rem_d    = rem_q;
    drop_d   = drop_q;
    msg_wr   = 1'b0;
    msg_done = 1'b0;
    msg_err  = 1'b0;
    in_len   = hdr_len(in_msg);
    fits     = (32'(msg_free) >= (32'(in_len) + 32'd1));
    if (in_msg_nd) begin
      unique case (trk_q)
        TRK_EXP_HDR: begin
          if (!in_msg[`MSG_HDR_BIT]) begin
            msg_err = 1'b1;
          end else begin
            drop_d  = !fits;
            msg_err = !fits;
            msg_wr  = fits;
            if (in_len == '0) begin
              msg_done = fits;
            end else begin
              trk_d = TRK_IN_PAYLOAD;
              rem_d = in_len;
            end
          end
        end
        TRK_IN_PAYLOAD: begin
          msg_wr = !drop_q;
          rem_d  = rem_q - 1'b1;
          if (rem_q == msg_len_t'(1)) begin
            trk_d    = TRK_EXP_HDR;
            msg_done = !drop_q;
          end
        end
        default: trk_d = TRK_EXP_HDR;
      endcase
    end
  end

  // A message completing this cycle counts as available now, so its header leaves two cycles later.
  assign msg_avail = (cnt_q != '0) || msg_done;
`ifdef SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN
  assign msg_eligible = msg_avail;
`else
  assign msg_eligible = msg_avail && smp_empty;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (msg_done && !cnt_dec)      cnt_d = cnt_q + 1'b1;
    else if (cnt_dec && !msg_done) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:         if (msg_eligible) state_d = ST_SEND_HDR;
      ST_SEND_HDR:     state_d = (hdr_len(msg_rdata) == '0) ? ST_IDLE : ST_SEND_PAYLOAD;
      ST_SEND_PAYLOAD: if (pay_cnt_q == msg_len_t'(1)) state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_nd_d   = 1'b0;
    out_data_d = '0;
    smp_rd     = 1'b0;
    msg_rd     = 1'b0;
    cnt_dec    = 1'b0;
    pay_cnt_d  = pay_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!msg_eligible && !smp_empty) begin
          smp_rd     = 1'b1;
          out_nd_d   = 1'b1;
          out_data_d = smp_rdata;
        end
      end
      ST_SEND_HDR: begin
        msg_rd     = 1'b1;
        out_nd_d   = 1'b1;
        out_data_d = WDTH'(msg_rdata);
        pay_cnt_d  = hdr_len(msg_rdata);
        cnt_dec    = 1'b1;
      end
      ST_SEND_PAYLOAD: begin
        msg_rd     = 1'b1;
        out_nd_d   = 1'b1;
        out_data_d = WDTH'(msg_rdata);
        pay_cnt_d  = pay_cnt_q - 1'b1;
      end
      default: ;
    endcase
  end

  assign error_d = smp_err || msg_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      trk_q      <= TRK_EXP_HDR;
      rem_q      <= '0;
      drop_q     <= 1'b0;
      cnt_q      <= '0;
      pay_cnt_q  <= '0;
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      trk_q      <= trk_d;
      rem_q      <= rem_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      pay_cnt_q  <= pay_cnt_d;
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
      error_q    <= error_d;
    end
  end

  assign out_data = out_data_q;
  assign out_nd   = out_nd_q;
  assign error    = error_q;

endmodule

// File: tb/tb_sample_msg_combiner.sv
// Self-checking bench for sample_msg_combiner: per-cycle vector table plus hand sequences
// for oversize-message drop and mid-message reset.
module tb_sample_msg_combiner;

  typedef struct {
    logic        snd;
    logic [31:0] sdat;
    logic        mnd;
    logic [31:0] mdat;
    logic        ond;
    logic [31:0] odat;
    logic        err;
  } vec_t;

  localparam int unsigned NV = 48;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_samples = '0;
  logic        in_samples_nd = 1'b0;
  logic [31:0] in_msg = '0;
  logic        in_msg_nd = 1'b0;
  logic [31:0] out_data;
  logic        out_nd;
  logic        error;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned err_seen = 0;
  logic [31:0] outq [$];
  vec_t        vec [NV];

  always #5 clk = ~clk;

  sample_msg_combiner #(.WDTH(32), .SAMPLE_BUF_LOG(6), .MSG_BUF_LOG(6)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_samples    (in_samples),
    .in_samples_nd (in_samples_nd),
    .in_msg        (in_msg),
    .in_msg_nd     (in_msg_nd),
    .out_data      (out_data),
    .out_nd        (out_nd),
    .error         (error)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickm();
    tick();
    if (out_nd) outq.push_back(out_data);
    if (error) err_seen++;
  endtask

  task automatic vexp(input int idx, input logic [31:0] d);
    vec[idx].ond  = 1'b1;
    vec[idx].odat = d;
  endtask

  task automatic vmsg(input int idx, input logic [31:0] d);
    vec[idx].mnd  = 1'b1;
    vec[idx].mdat = d;
  endtask

  initial begin
    for (int i = 0; i < NV; i++) vec[i] = '{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0};

    // Samples 1..5 emerge two cycles later
    for (int k = 0; k < 5; k++) begin
      vec[k].snd  = 1'b1;
      vec[k].sdat = 32'(k + 1);
      vexp(k + 2, 32'(k + 1));
    end
    // Header L=2 and two payload words, no samples
    vmsg(10, 32'h8000_0002); vmsg(11, 32'h1234_5678); vmsg(12, 32'h9ABC_DEF0);
    vexp(14, 32'h8000_0002); vexp(15, 32'h1234_5678); vexp(16, 32'h9ABC_DEF0);
    // Sample with MSB set: cleared on output, error one cycle after input
    vec[20].snd = 1'b1; vec[20].sdat = 32'h8000_0007;
    vec[21].err = 1'b1;
    vexp(22, 32'h0000_0007);
    // Message arriving amid a continuous sample stream
    for (int k = 0; k < 8; k++) begin
      vec[30 + k].snd  = 1'b1;
      vec[30 + k].sdat = 32'h100 + 32'(k);
    end
    vmsg(31, 32'h8000_0002); vmsg(32, 32'h0000_00A1); vmsg(33, 32'h0000_00A2);
`ifdef SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN
    vexp(32, 32'h100); vexp(33, 32'h101);
    vexp(35, 32'h8000_0002); vexp(36, 32'h0000_00A1); vexp(37, 32'h0000_00A2);
    for (int k = 2; k < 8; k++) vexp(36 + k, 32'h100 + 32'(k));
`else
    for (int k = 0; k < 8; k++) vexp(32 + k, 32'h100 + 32'(k));
    vexp(41, 32'h8000_0002); vexp(42, 32'h0000_00A1); vexp(43, 32'h0000_00A2);
`endif

    tick();
    tick();
    chk("reset_out_nd", {31'b0, out_nd}, 32'h0);
    chk("reset_out_data", out_data, 32'h0);
    chk("reset_error", {31'b0, error}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      chk($sformatf("row%0d_out_nd", i), {31'b0, out_nd}, {31'b0, vec[i].ond});
      chk($sformatf("row%0d_error", i), {31'b0, error}, {31'b0, vec[i].err});
      if (vec[i].ond) chk($sformatf("row%0d_out_data", i), out_data, vec[i].odat);
      in_samples    = vec[i].sdat;
      in_samples_nd = vec[i].snd;
      in_msg        = vec[i].mdat;
      in_msg_nd     = vec[i].mnd;
      tick();
    end
    in_samples_nd = 1'b0;
    in_msg_nd     = 1'b0;

    // Oversize message (L=70) into a 64-word buffer is dropped whole
    outq.delete();
    err_seen  = 0;
    in_msg    = 32'h8000_0046;
    in_msg_nd = 1'b1;
    tick();
    chk("ovf_hdr_error", {31'b0, error}, 32'h1);
    for (int k = 0; k < 70; k++) begin
      in_msg = 32'h8000_0000 | 32'(k);
      tickm();
    end
    in_msg = 32'h8000_0000;
    tickm();
    in_msg_nd = 1'b0;
    chk("zero_len_not_early", {31'b0, out_nd}, 32'h0);
    tickm();
    chk("zero_len_nd", {31'b0, out_nd}, 32'h1);
    chk("zero_len_data", out_data, 32'h8000_0000);
    for (int k = 0; k < 4; k++) tickm();
    chk("ovf_out_count", 32'(outq.size()), 32'd1);
    chk("ovf_extra_errors", err_seen, 32'd0);

    // Reset in the middle of a message
    outq.delete();
    err_seen  = 0;
    in_msg    = 32'h8000_0003;
    in_msg_nd = 1'b1;
    tickm();
    in_msg = 32'h0000_0011;
    tickm();
    in_msg_nd = 1'b0;
    reset     = 1'b1;
    tickm();
    chk("rst_out_nd", {31'b0, out_nd}, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_error", {31'b0, error}, 32'h0);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) tickm();
    chk("rst_no_partial", 32'(outq.size()), 32'd0);
    in_msg    = 32'h8000_0001;
    in_msg_nd = 1'b1;
    tickm();
    in_msg = 32'h0000_0055;
    tickm();
    in_msg_nd = 1'b0;
    for (int k = 0; k < 6; k++) tickm();
    chk("post_rst_count", 32'(outq.size()), 32'd2);
    if (outq.size() == 2) begin
      chk("post_rst_hdr", outq[0], 32'h8000_0001);
      chk("post_rst_payload", outq[1], 32'h0000_0055);
    end
    chk("post_rst_errors", err_seen, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
